// File: rtl/ct_arbiter_if.sv
// rtl/ct_arbiter_if.sv - request/grant and ct_mem port bundle for ct_arbiter
interface ct_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rddata;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_rddata;

    // cores plus the memory side
    modport master (
        output req, lock, req_addr, mem_rddata,
        input  gnt, rvalid, rddata, mem_addr
    );

    // arbiter side
    modport slave (
        input  req, lock, req_addr, mem_rddata,
        output gnt, rvalid, rddata, mem_addr
    );
endinterface

// File: rtl/ct_arbiter.sv
// rtl/ct_arbiter.sv - round-robin arbiter with bounded burst lock sharing one ct_mem
module ct_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    ct_arbiter_if.slave  io_bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    ptr_t              r_rr_ptr;
    ptr_t              r_owner;
    logic [3:0]        r_burst_cnt;
    logic [N_REQ-1:0]  r_rv_q;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_scan_hit;
    ptr_t              w_scan_idx;
    ptr_t              w_next_ptr;
    logic              w_gnt_hit;
    ptr_t              w_gnt_idx;
    logic [N_REQ-1:0]  w_gnt;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [3:0]        w_cnt_next;
    logic              w_burst_done;
    logic              w_take_lock;

    // first requester at or after the round-robin pointer, wrapping
    always_comb begin
        int v_j;
        v_j        = 0;
        w_scan_hit = 1'b0;
        w_scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_j = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_scan_hit && io_bus.req[ptr_t'(v_j)]) begin
                w_scan_hit = 1'b1;
                w_scan_idx = ptr_t'(v_j);
            end
        end
    end

    assign w_next_ptr   = (w_scan_idx == ptr_t'(N_REQ - 1)) ? '0 : w_scan_idx + ptr_t'(1);
    assign w_cnt_next   = r_burst_cnt + 4'd1;
    assign w_burst_done = (w_cnt_next >= 4'(MAX_BURST));
    assign w_take_lock  = w_scan_hit && io_bus.lock[w_scan_idx] && (MAX_BURST > 1);

    // select the granted requester: the lock owner only, or the scan winner
    always_comb begin
        w_gnt_hit = 1'b0;
        w_gnt_idx = r_owner;
        if (!rst) begin
            if (r_state == ST_LOCKED) begin
                w_gnt_hit = io_bus.req[r_owner];
            end else begin
                w_gnt_hit = w_scan_hit;
                w_gnt_idx = w_scan_idx;
            end
        end
        w_gnt = '0;
        if (w_gnt_hit) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign w_gnt_addr = io_bus.req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];

    // lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // lock taken on an unlocked grant with lock set; dropped on idle owner, lock low or burst limit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RR: begin
                if (w_take_lock) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!io_bus.req[r_owner] || !io_bus.lock[r_owner] || w_burst_done) begin
                    w_state_next = ST_RR;
                end
            end
            default: w_state_next = ST_RR;
        endcase
    end

    // pointer, owner, burst count and the read-return valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= 4'd0;
            r_rv_q      <= '0;
        end else begin
            r_rv_q <= w_gnt;
            if (r_state == ST_RR) begin
                if (w_scan_hit) begin
                    r_rr_ptr <= w_next_ptr;
                    if (w_take_lock) begin
                        r_owner     <= w_scan_idx;
                        r_burst_cnt <= 4'd1;
                    end
                end
            end else if (io_bus.req[r_owner]) begin
                r_burst_cnt <= w_cnt_next;
            end
        end
    end

    // last granted address is held so mem_addr never floats once a grant has happened
    always_ff @(posedge clk) begin
        if (w_gnt_hit) begin
            r_mem_addr <= w_gnt_addr;
        end
    end

    assign io_bus.gnt      = w_gnt;
    assign io_bus.rvalid   = r_rv_q;
    assign io_bus.rddata   = io_bus.mem_rddata;
    assign io_bus.mem_addr = w_gnt_hit ? w_gnt_addr : r_mem_addr;
endmodule

// File: tb/tb_ct_arbiter.sv
// tb/tb_ct_arbiter.sv - randomized and directed bench for ct_arbiter against a behavioural model
module tb_ct_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [DW-1:0] mem [256];

    ct_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ct_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_rddata <= mem[bus.mem_addr];

    // model state
    int        m_ptr = 0;
    int        m_locked = 0;
    int        m_owner = 0;
    int        m_cnt = 0;
    int        m_prev_gnt = -1;
    logic [AW-1:0] m_prev_addr = '0;
    logic [AW-1:0] m_last_addr = '0;
    int        m_seen = 0;
    int        m_wait [N];
    bit        done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return bus.req_addr[i*AW +: AW];
    endfunction

    // compare process: checks every cycle just before the rising edge, then advances the model
    initial begin
        int win;
        logic [N-1:0] egnt;
        logic [N-1:0] ervalid;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        while (!done) begin
            @(negedge clk);
            win = -1;
            if (!rst) begin
                if (m_locked != 0) begin
                    if (bit_of(bus.req, m_owner)) win = m_owner;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (win < 0 && bit_of(bus.req, (m_ptr + k) % N)) win = (m_ptr + k) % N;
                    end
                end
            end
            egnt    = (win >= 0) ? (N'(1) << win) : '0;
            ervalid = (m_prev_gnt >= 0) ? (N'(1) << m_prev_gnt) : '0;
            chk("gnt", 32'(bus.gnt), 32'(egnt));
            chk("rvalid", 32'(bus.rvalid), 32'(ervalid));
            if (m_prev_gnt >= 0) chk("rddata", 32'(bus.rddata), 32'(mem[m_prev_addr]));
            if (win >= 0) chk("mem_addr", 32'(bus.mem_addr), 32'(addr_of(win)));
            else if (m_seen != 0) chk("mem_addr_hold", 32'(bus.mem_addr), 32'(m_last_addr));

            for (int i = 0; i < N; i++) begin
                if (rst || !bit_of(bus.req, i) || win == i) begin
                    m_wait[i] = 0;
                end else if (win >= 0) begin
                    m_wait[i]++;
                    chk("fair_wait", 32'(m_wait[i] <= (N - 1) * MB), 32'd1);
                end
            end

            if (rst) begin
                m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
            end else if (m_locked != 0) begin
                if (bit_of(bus.req, m_owner)) begin
                    m_cnt++;
                    if (!bit_of(bus.lock, m_owner) || m_cnt == MB) m_locked = 0;
                end else begin
                    m_locked = 0;
                end
            end else if (win >= 0) begin
                m_ptr = (win + 1) % N;
                if (bit_of(bus.lock, win) && MB > 1) begin
                    m_locked = 1; m_owner = win; m_cnt = 1;
                end
            end
            m_prev_gnt = win;
            if (win >= 0) begin
                m_prev_addr = addr_of(win);
                m_last_addr = addr_of(win);
                m_seen = 1;
            end
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs);
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.lock = l;
        rst      = rs;
        #1;
    endtask

    logic [N-1:0] exp_seq [9];
    logic [N-1:0] lock_seq [6];

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = DW'($urandom);
        mem[5] = 8'hA7;
        bus.req      = '0;
        bus.lock     = '0;
        bus.req_addr = {8'h33, 8'h22, 8'h11, 8'h05};

        // reset, then single requester at 0x05
        cyc(4'b1111, 4'b0000, 1'b1); chk("rst_gnt", 32'(bus.gnt), 32'd0);
        cyc(4'b1111, 4'b0000, 1'b1); chk("rst_gnt", 32'(bus.gnt), 32'd0);
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("single_gnt", 32'(bus.gnt), 32'b0001);
        chk("single_addr", 32'(bus.mem_addr), 32'h05);
        chk("single_rv0", 32'(bus.rvalid), 32'd0);
        for (int c = 0; c < 2; c++) begin
            cyc(4'b0001, 4'b0000, 1'b0);
            chk("single_gnt", 32'(bus.gnt), 32'b0001);
            chk("single_rv", 32'(bus.rvalid), 32'b0001);
            chk("single_data", 32'(bus.rddata), 32'hA7);
        end

        // all request, no lock
        cyc(4'b0000, 4'b0000, 1'b1);
        for (int c = 0; c < 8; c++) begin
            cyc(4'b1111, 4'b0000, 1'b0);
            chk("rr_all", 32'(bus.gnt), 32'(N'(1) << (c % 4)));
        end

        // pointer after a lone grant to 2
        cyc(4'b0100, 4'b0000, 1'b0); chk("ptr_g2", 32'(bus.gnt), 32'b0100);
        cyc(4'b1011, 4'b0000, 1'b0); chk("ptr_g3", 32'(bus.gnt), 32'b1000);
        cyc(4'b1011, 4'b0000, 1'b0); chk("ptr_g0", 32'(bus.gnt), 32'b0001);
        cyc(4'b1011, 4'b0000, 1'b0); chk("ptr_g1", 32'(bus.gnt), 32'b0010);

        // burst lock by requester 0
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};
        cyc(4'b0000, 4'b0000, 1'b1);
        for (int c = 0; c < 9; c++) begin
            cyc(4'b1111, 4'b0001, 1'b0);
            chk("burst", 32'(bus.gnt), 32'(exp_seq[c]));
        end

        // lock by requester 1 released early
        lock_seq   = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        exp_seq[0:5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cyc(4'b0000, 4'b0000, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cyc(4'b1111, lock_seq[c], 1'b0);
            chk("early_rel", 32'(bus.gnt), 32'(exp_seq[c]));
        end

        // reset during the second locked grant
        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b1111, 4'b0001, 1'b0); chk("midrst_a", 32'(bus.gnt), 32'b0001);
        cyc(4'b1111, 4'b0001, 1'b0); chk("midrst_b", 32'(bus.gnt), 32'b0001);
        cyc(4'b1111, 4'b0001, 1'b1); chk("midrst_gnt", 32'(bus.gnt), 32'd0);
        cyc(4'b1111, 4'b0000, 1'b0);
        chk("midrst_rv", 32'(bus.rvalid), 32'd0);
        chk("midrst_win", 32'(bus.gnt), 32'b0001);

        // randomized traffic; a request stays put until the model says it was granted
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            @(posedge clk);
            #1;
            r = bus.req;
            for (int i = 0; i < N; i++) begin
                if (!(r[i] && m_prev_gnt != i)) begin
                    r[i] = ($urandom_range(0, 3) != 0);
                    bus.req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            bus.req  = r;
            bus.lock = N'($urandom);
            rst      = ($urandom_range(0, 63) == 0);
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req = '0;
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
